// File: rtl/dac_dsp_serializer_pkg.sv
// Shared constants and types for the WM8731 DSP-mode A sample serializer.
package dac_dsp_serializer_pkg;

    localparam int unsigned SAMPLE_W        = 16;
    localparam int unsigned DEF_FRAME_BCLKS = 250;
    localparam int unsigned DEF_BCLK_HALF   = 1;

    // BCLK slot numbering inside one frame
    localparam int unsigned LRC_SLOT = 0;
    localparam int unsigned L_FIRST  = 1;
    localparam int unsigned R_FIRST  = SAMPLE_W + 1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        SLOT_LRC,
        SLOT_LEFT,
        SLOT_RIGHT,
        SLOT_IDLE
    } slot_e;

    // Classify a frame slot index into sync, left data, right data or padding.
    function automatic slot_e slot_of(input int unsigned cnt);
        if (cnt == LRC_SLOT) begin
            return SLOT_LRC;
        end else if (cnt >= L_FIRST && cnt < R_FIRST) begin
            return SLOT_LEFT;
        end else if (cnt >= R_FIRST && cnt < R_FIRST + SAMPLE_W) begin
            return SLOT_RIGHT;
        end
        return SLOT_IDLE;
    endfunction

endpackage

// File: rtl/dac_dsp_serializer_if.sv
// Sample stream from the memory fetcher into the serializer (valid/ready).
interface dac_dsp_serializer_if;
    import dac_dsp_serializer_pkg::*;

    logic    s_valid;
    logic    s_ready;
    sample_t s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/dac_dsp_serializer_bclk_gen.sv
// Bit-clock divider: aud_bclk = clk/(2*BCLK_HALF), plus a one-clk strobe on
// the clk edge where aud_bclk falls.
module dac_dsp_serializer_bclk_gen #(
    parameter int unsigned BCLK_HALF = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic aud_bclk,
    output logic fall_evt
);

    localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             terminal;

    // Half-period counter; toggles bclk at terminal count.
    always_comb begin
        terminal  = (div_cnt_q == DIV_TC);
        div_cnt_d = terminal ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d    = terminal ? ~bclk_q : bclk_q;
        fall_evt  = terminal && bclk_q;
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign aud_bclk = bclk_q;

endmodule

// File: rtl/dac_dsp_serializer.sv
// Serializes 16-bit mono PCM samples to the WM8731 DAC in DSP mode A,
// duplicating each sample into the left and right slots. A one-entry holding
// buffer decouples the fetcher from the frame timing; when a frame starts with
// the buffer empty the previous sample is repeated and underrun pulses.
module dac_dsp_serializer
    import dac_dsp_serializer_pkg::*;
#(
    parameter int unsigned FRAME_BCLKS = DEF_FRAME_BCLKS,
    parameter int unsigned BCLK_HALF   = DEF_BCLK_HALF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dac_dsp_serializer_if.slave  s_if,
    output logic                 aud_bclk,
    output logic                 aud_daclrck,
    output logic                 aud_dacdat,
    output logic                 frame_start,
    output logic                 underrun
);

    localparam int unsigned    BCW      = $clog2(FRAME_BCLKS);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BCLKS - 1);
    localparam int unsigned    SHIFT_W  = 2 * SAMPLE_W;

    logic                fall_evt;

    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d, bit_cnt_nxt;
    sample_t             hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    sample_t             last_q, last_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                lrck_q, lrck_d;
    logic                dacdat_q, dacdat_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                xfer;
    logic                load;
    slot_e               slot_nxt;

    dac_dsp_serializer_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .aud_bclk (aud_bclk),
        .fall_evt (fall_evt)
    );

    // Frame slot sequencing, shifter and holding-buffer handshake.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        last_d        = last_q;
        shift_d       = shift_q;
        lrck_d        = lrck_q;
        dacdat_d      = dacdat_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        load          = 1'b0;

        xfer        = s_if.s_valid && !hold_full_q;
        bit_cnt_nxt = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BCW'(1);
        slot_nxt    = slot_of(32'(bit_cnt_nxt));

        if (fall_evt) begin
            bit_cnt_d = bit_cnt_nxt;
            case (slot_nxt)
                SLOT_LRC: begin
                    lrck_d        = 1'b1;
                    dacdat_d      = 1'b0;
                    frame_start_d = 1'b1;
                    load          = 1'b1;
                    // Buffer contents as they stood before this clk; an
                    // upstream transfer in the same clk lands in the next frame.
                    if (hold_full_q) begin
                        shift_d = {hold_q, hold_q};
                        last_d  = hold_q;
                    end else begin
                        shift_d    = {last_q, last_q};
                        underrun_d = 1'b1;
                    end
                end
                SLOT_LEFT, SLOT_RIGHT: begin
                    lrck_d   = 1'b0;
                    dacdat_d = shift_q[SHIFT_W-1];
                    shift_d  = {shift_q[SHIFT_W-2:0], 1'b0};
                end
                SLOT_IDLE: begin
                    lrck_d   = 1'b0;
                    dacdat_d = 1'b0;
                end
                default: begin
                    lrck_d   = 1'b0;
                    dacdat_d = 1'b0;
                end
            endcase
        end

        if (xfer) begin
            hold_d      = s_if.s_data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    // Serializer and buffer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q     <= BIT_LAST;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            last_q        <= '0;
            shift_q       <= '0;
            lrck_q        <= 1'b0;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            last_q        <= last_d;
            shift_q       <= shift_d;
            lrck_q        <= lrck_d;
            dacdat_q      <= dacdat_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_if.s_ready = ~hold_full_q;
    assign aud_daclrck  = lrck_q;
    assign aud_dacdat   = dacdat_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_dac_dsp_serializer.sv
// Bench for dac_dsp_serializer: a cycle-indexed behavioural model plus
// literal spot checks of frame timing and decoded serial words.
module tb_dac_dsp_serializer;
    import dac_dsp_serializer_pkg::*;

    localparam int FR = 250;
    localparam int BH = 1;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun;

    dac_dsp_serializer_if s_if();

    dac_dsp_serializer #(
        .FRAME_BCLKS (FR),
        .BCLK_HALF   (BH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_if        (s_if),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k counts clk edges since reset release; bit clock, slot position and
    // frame boundaries follow from it arithmetically.
    int          m_k;
    bit          m_full, m_fs, m_ur, m_old_full, m_is_frame;
    logic [15:0] m_hold, m_last, m_frame;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_k = 0; m_full = 0; m_hold = '0; m_last = '0;
                m_frame = '0; m_fs = 0; m_ur = 0;
            end else begin
                m_old_full = m_full;
                m_k++;
                m_is_frame = (m_k % (2*BH) == 0) && (((m_k / (2*BH)) - 1) % FR == 0);
                m_fs = m_is_frame;
                m_ur = m_is_frame && !m_old_full;
                if (m_is_frame) begin
                    if (m_old_full) begin
                        m_frame = m_hold;
                        m_last  = m_hold;
                        m_full  = 0;
                    end else begin
                        m_frame = m_last;
                    end
                end
                if (s_if.s_valid && !m_old_full) begin
                    m_hold = s_if.s_data;
                    m_full = 1;
                end
            end
        end
    end

    int   c_f, c_pos;
    logic [5:0] c_exp, c_act;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && reset_n) begin
                c_f   = m_k / (2*BH);
                c_pos = (c_f + FR - 1) % FR;
                c_exp[5] = ((m_k / BH) % 2) == 1;
                c_exp[4] = (c_f > 0) && (c_pos == 0);
                c_exp[3] = 1'b0;
                if (c_f > 0 && c_pos >= 1 && c_pos <= W)
                    c_exp[3] = m_frame[W - c_pos];
                else if (c_f > 0 && c_pos > W && c_pos <= 2*W)
                    c_exp[3] = m_frame[2*W - c_pos];
                c_exp[2] = m_fs;
                c_exp[1] = m_ur;
                c_exp[0] = !m_full;
                c_act = {aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, s_if.s_ready};
                n_tests++;
                if (c_act !== c_exp) begin
                    n_fail++;
                    $display("FAIL cycle_model k=%0d pos=%0d: bclk/lrck/dat/fs/ur/rdy got %b, expected %b",
                             m_k, c_pos, c_act, c_exp);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 1200);
        if (!frame_start) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_fs: no frame_start within %0d clks, got 0, expected 1", n);
        end
    endtask

    task automatic read_bits(output logic [31:0] v);
        v = '0;
        for (int i = 0; i < 2*W; i++) begin
            repeat (2*BH) @(negedge clk);
            v = {v[30:0], aud_dacdat};
        end
    endtask

    task automatic decode(output logic [15:0] l, output logic [15:0] r, output logic ur);
        int n;
        logic [31:0] v;
        wait_fs(n);
        ur = underrun;
        read_bits(v);
        l = v[31:16];
        r = v[15:0];
    endtask

    task automatic push(input logic [15:0] d);
        int n;
        n = 0;
        while (!s_if.s_ready && n < 1200) begin
            @(negedge clk);
            n++;
        end
        if (!s_if.s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push: s_ready stuck, got 0, expected 1");
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        @(negedge clk);
        s_if.s_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          n, xf, fs;
    bit          prev;
    logic [15:0] l, r, d;
    logic        ur;
    logic [31:0] v;

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_state", {26'd0, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, s_if.s_ready},
            32'b000001);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // idle: frame timing and underrun every frame
        wait_fs(n);
        chk("first_frame_delay", n, 2*BH);
        chk("idle_underrun0", underrun, 1);
        wait_fs(n);
        chk("frame_period", n, 2*BH*FR);
        chk("idle_underrun1", underrun, 1);

        // single sample
        repeat ($urandom_range(1, 100)) @(negedge clk);
        push(16'hA5C3);
        decode(l, r, ur);
        chk("a5c3_left", l, 16'hA5C3);
        chk("a5c3_right", r, 16'hA5C3);
        chk("a5c3_underrun", ur, 0);

        // continuous feed of incrementing data
        d = 16'($urandom_range(0, 65535));
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        prev = s_if.s_ready;
        xf = 0; fs = 0; n = 0;
        while (fs < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (prev) begin
                xf++;
                s_if.s_data = s_if.s_data + 16'd1;
            end
            if (frame_start) fs++;
            prev = s_if.s_ready && s_if.s_valid;
        end
        s_if.s_valid = 1'b0;
        chk("stream_frames", fs, 4);
        chk("stream_xfers", xf, 4);

        // transfer on the very clk of a frame load
        wait_fs(n);
        repeat (2*BH*FR - 1) @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 16'h1234;
        @(negedge clk);
        s_if.s_valid = 1'b0;
        chk("coinc_fs", frame_start, 1);
        chk("coinc_underrun", underrun, 1);
        chk("coinc_ready", s_if.s_ready, 0);
        decode(l, r, ur);
        chk("coinc_next_left", l, 16'h1234);
        chk("coinc_next_right", r, 16'h1234);
        chk("coinc_next_underrun", ur, 0);

        // starvation repeats the last sample
        push(16'h8001);
        decode(l, r, ur);
        chk("last_first_left", l, 16'h8001);
        chk("last_first_underrun", ur, 0);
        decode(l, r, ur);
        chk("repeat_left", l, 16'h8001);
        chk("repeat_right", r, 16'h8001);
        chk("repeat_underrun", ur, 1);

        // reset in the middle of the left sample
        wait_fs(n);
        repeat (20*BH) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {26'd0, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, s_if.s_ready},
            32'b000001);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_fs(n);
        chk("postreset_delay", n, 2*BH);
        chk("postreset_underrun", underrun, 1);
        read_bits(v);
        chk("postreset_data", v, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
